// File: rtl/booth_pkg.sv
// Shared types for the sequential radix-2 Booth multiplier: width default,
// controller state encoding and the per-step Booth operation decode.
package booth_pkg;

    localparam int BOOTH_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        OP_NOP,
        OP_ADD,
        OP_SUB
    } booth_op_e;

    // {Q[0], q_m1}: 01 -> add M, 10 -> subtract M, otherwise no add
    function automatic booth_op_e booth_decode(input logic q0, input logic q_m1);
        case ({q0, q_m1})
            2'b01:   return OP_ADD;
            2'b10:   return OP_SUB;
            default: return OP_NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational Booth iteration: optional add/sub of M into Acc, then an
// arithmetic right shift of {Acc, Q, q_m1} by one bit.
module booth_step
    import booth_pkg::*;
#(
    parameter int WIDTH = BOOTH_WIDTH
) (
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] q,
    input  logic             q_m1,
    input  logic [WIDTH:0]   m,
    output logic [WIDTH:0]   acc_next,
    output logic [WIDTH-1:0] q_next,
    output logic             q_m1_next
);

    booth_op_e        op;
    logic [WIDTH:0]   sum;

    always_comb begin
        op = booth_decode(q[0], q_m1);
        unique case (op)
            OP_ADD:  sum = acc + m;
            OP_SUB:  sum = acc - m;
            default: sum = acc;
        endcase
        acc_next  = {sum[WIDTH], sum[WIDTH:1]};
        q_next    = {sum[0], q[WIDTH-1:1]};
        q_m1_next = q[0];
    end

endmodule

// File: rtl/booth_seq_ctrl.sv
// Sequential radix-2 Booth multiply controller: valid/ready operand intake,
// WIDTH add/sub/shift steps over one shared WIDTH+1-bit adder, held result.
module booth_seq_ctrl
    import booth_pkg::*;
#(
    parameter int WIDTH = BOOTH_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e               state_q, state_d;
    logic [WIDTH:0]       m_q, m_d;
    logic [WIDTH:0]       acc_q, acc_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic                 q_m1_q, q_m1_d;
    logic [CW-1:0]        count_q, count_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 in_ready_q, in_ready_d;
    logic                 busy_q, busy_d;
    logic                 out_valid_q, out_valid_d;

    logic [WIDTH:0]       acc_step;
    logic [WIDTH-1:0]     q_step;
    logic                 q_m1_step;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .acc       (acc_q),
        .q         (q_q),
        .q_m1      (q_m1_q),
        .m         (m_q),
        .acc_next  (acc_step),
        .q_next    (q_step),
        .q_m1_next (q_m1_step)
    );

    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        acc_d    = acc_q;
        q_d      = q_q;
        q_m1_d   = q_m1_q;
        count_d  = count_q;
        result_d = result_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    m_d     = {a[WIDTH-1], a};
                    acc_d   = '0;
                    q_d     = b;
                    q_m1_d  = 1'b0;
                    count_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d   = acc_step;
                q_d     = q_step;
                q_m1_d  = q_m1_step;
                count_d = count_q + 1'b1;
                if (count_q == CW'(WIDTH - 1)) begin
                    result_d = {acc_step[WIDTH-1:0], q_step};
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Status outputs are registered from the next state so they track state_q exactly
        in_ready_d  = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            m_q         <= '0;
            acc_q       <= '0;
            q_q         <= '0;
            q_m1_q      <= 1'b0;
            count_q     <= '0;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            acc_q       <= acc_d;
            q_q         <= q_d;
            q_m1_q      <= q_m1_d;
            count_q     <= count_d;
            result_q    <= result_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Self-checking bench for booth_seq_ctrl: directed and random operand pairs
// checked against a signed 64-bit multiply reference.
module tb_booth_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        busy;

    int total = 0;
    int bad   = 0;

    booth_seq_ctrl #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_i),
        .b         (b_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        longint sx;
        longint sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        return 64'(sx * sy);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One full transaction; bp = cycles of out_ready low once valid, noise = junk on inputs during RUN
    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input int bp, input bit noise);
        logic [63:0] exp;
        int lat;
        int w;
        exp = ref_mul(x, y);
        w = 0;
        while (!in_ready && w < 100) begin
            tick();
            w++;
        end
        chk("idle_before_op", 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        a_i       = x;
        b_i       = y;
        out_ready = (bp == 0);
        tick();
        lat = 0;
        if (!noise) in_valid = 1'b0;
        while (!out_valid && lat < 100) begin
            chk("run_in_ready", 64'(in_ready), 64'd0);
            chk("run_busy", 64'(busy), 64'd1);
            if (noise) begin
                a_i = $urandom;
                b_i = $urandom;
            end
            tick();
            lat++;
        end
        in_valid = 1'b0;
        chk("latency", 64'(lat), 64'd32);
        chk("product", result, exp);
        for (int i = 0; i < bp; i++) begin
            tick();
            chk("bp_valid_held", 64'(out_valid), 64'd1);
            chk("bp_result_stable", result, exp);
        end
        out_ready = 1'b1;
        tick();
        chk("post_accept_in_ready", 64'(in_ready), 64'd1);
        chk("post_accept_valid", 64'(out_valid), 64'd0);
        chk("result_kept_idle", result, exp);
        out_ready = 1'b0;
    endtask

    logic [31:0] pa [8];
    logic [31:0] pb [8];
    logic [63:0] expq [$];

    initial begin
        int idx;
        int got;
        int cyc;
        int last_acc;
        int seen_valid;
        logic [63:0] e;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a_i = '0; b_i = '0;
        tick();
        tick();
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_result", result, 64'd0);
        rst = 1'b0;
        tick();

        run_op(32'd50, -32'sd40, 0, 1'b0);
        chk("const_m2000", result, 64'hFFFF_FFFF_FFFF_F830);
        run_op(-32'sd80, -32'sd65, 0, 1'b0);
        run_op(-32'sd999, 32'sd999, 0, 1'b0);
        run_op(32'h8000_0000, 32'h8000_0000, 0, 1'b0);
        chk("const_2pow62", result, 64'h4000_0000_0000_0000);
        run_op(32'h7FFF_FFFF, 32'h8000_0000, 0, 1'b0);
        chk("const_max_min", result, 64'hC000_0000_8000_0000);
        run_op(32'd98765, 32'd1, 0, 1'b0);
        run_op(32'd98756, 32'd0, 0, 1'b0);
        run_op(32'd12345, -32'sd678, 0, 1'b1);
        run_op(-32'sd500, 32'sd2000, 10, 1'b0);

        // Reset during RUN: abort, no result for the aborted pair
        in_valid = 1'b1; a_i = 32'd90; b_i = 32'd70;
        tick();
        in_valid = 1'b0;
        repeat (15) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_result", result, 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        seen_valid = 0;
        repeat (40) begin
            tick();
            if (out_valid) seen_valid++;
        end
        chk("abort_no_result", 64'(seen_valid), 64'd0);
        run_op(-32'sd10, 32'sd325, 0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            run_op($urandom, $urandom, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        // Back-to-back with in_valid and out_ready held high
        for (int i = 0; i < 8; i++) begin
            pa[i] = $urandom;
            pb[i] = (i == 0) ? 32'h8000_0000 : $urandom;
        end
        idx = 0; got = 0; cyc = 0; last_acc = 0;
        in_valid = 1'b1; out_ready = 1'b1; a_i = pa[0]; b_i = pb[0];
        while (got < 8 && cyc < 400) begin
            if (out_valid) begin
                if (expq.size() == 0) begin
                    chk("b2b_extra_result", result, 64'hDEAD_DEAD_DEAD_DEAD);
                end else begin
                    e = expq.pop_front();
                    chk("b2b_product", result, e);
                end
                got++;
            end
            if (in_ready && idx < 8) begin
                expq.push_back(ref_mul(a_i, b_i));
                if (idx > 0) chk("b2b_interval", 64'(cyc - last_acc), 64'd34);
                last_acc = cyc;
                idx++;
                @(posedge clk);
                #1;
                if (idx < 8) begin
                    a_i = pa[idx];
                    b_i = pb[idx];
                end else begin
                    in_valid = 1'b0;
                end
                @(negedge clk);
            end else begin
                tick();
            end
            cyc++;
        end
        chk("b2b_results", 64'(got), 64'd8);
        chk("b2b_accepts", 64'(idx), 64'd8);
        chk("b2b_queue_empty", 64'(expq.size()), 64'd0);
        in_valid = 1'b0;
        out_ready = 1'b0;
        seen_valid = 0;
        repeat (40) begin
            tick();
            if (out_valid) seen_valid++;
        end
        chk("b2b_no_dup", 64'(seen_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/booth_seq_ctrl.md
# booth_seq_ctrl

Sequential radix-2 Booth multiply controller. It accepts a signed operand pair over a valid/ready handshake and runs a 32-step Booth add/subtract/shift FSM over one shared adder. It returns the signed double-width product over a second valid/ready handshake. It is the area-lean, multi-cycle counterpart to the combinational Booth multiplier and drops in wherever a multiply may take WIDTH+1 cycles.

## Interface
- WIDTH, 32, operand width in bits; product is 2*WIDTH bits, two's complement.
- clk  in  1  rising-edge clock, sole clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair a/b valid.
- in_ready  out  1  controller idle and able to accept a pair.
- a  in  WIDTH  signed multiplicand.
- b  in  WIDTH  signed multiplier.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts result.
- result  out  2*WIDTH  signed product a*b.
- busy  out  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE.
- in_ready = (state==IDLE), busy = (state!=IDLE), out_valid = (state==DONE). No combinational path from inputs to outputs.
- IDLE, when in_valid&&in_ready at an edge:
  - Latch M = a sign-extended to WIDTH+1 bits.
  - Load Acc = 0 (WIDTH+1 bits), Q = b, q_m1 = 0, count = 0.
  - Go to RUN.
- RUN, one step per cycle, selected by {Q[0], q_m1}:
  - 01: Acc = Acc + M.
  - 10: Acc = Acc - M.
  - 00 or 11: Acc unchanged.
  - Then arithmetic-shift {Acc,Q,q_m1} right by 1, with Acc MSB replicated. Increment count.
  - After step WIDTH (count reaches WIDTH), go to DONE and load result = {Acc[WIDTH-1:0], Q}.
- The adder is WIDTH+1 bits wide so that M = -2^(WIDTH-1) never overflows. The -2^31 * -2^31 product (2^62) must be exact.
- DONE: result and out_valid held stable while out_ready is low. On out_valid&&out_ready, go to IDLE.
- result keeps its last value in IDLE. It changes only at the RUN->DONE edge.
- in_valid is ignored outside IDLE. No input queueing; the upstream must hold the pair until in_ready.
- Simultaneous output accept and new in_valid in DONE: only the output is accepted. The new pair is accepted no earlier than the following cycle, in IDLE.
- Reset has priority over all events, including mid-RUN or in DONE. The operation is aborted and no result is produced.

## Timing
- After any edge with rst=1: state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, count=0.
- Input handshake at edge T: RUN during cycles T..T+WIDTH-1; out_valid=1 from edge T+WIDTH. Latency is WIDTH cycles (32) from accept to valid.
- Output handshake at edge U: in_ready=1 from edge U. The earliest next accept is edge U+1.
- Maximum throughput is one product per WIDTH+2 cycles when out_ready is held high.
- The critical path is one WIDTH+1-bit add/sub plus a mux. No multi-cycle paths.

## Structure
- Shared package booth_pkg:
  - BOOTH_WIDTH default (32).
  - State enum {IDLE, RUN, DONE}.
  - Booth op encoding {NOP, ADD, SUB} decoded from {Q[0],q_m1}.
- Sub-module booth_step: a purely combinational single iteration.
  - Inputs: Acc, Q, q_m1, M.
  - Outputs: the next shifted Acc, Q, q_m1.
- The FSM, counter and handshake logic live in booth_seq_ctrl.

## Test plan
- a=50, b=-40, out_ready=1 -> out_valid exactly 32 cycles after accept, result=-2000 (0xFFFF_FFFF_FFFF_F830); a=-80, b=-65 -> 5200; a=-999, b=999 -> -998001.
- a=0x8000_0000, b=0x8000_0000 -> result=0x4000_0000_0000_0000; a=0x7FFF_FFFF, b=0x8000_0000 -> 0xC000_0000_8000_0000.
- a=98765, b=1 -> 98765; a=98756, b=0 -> 0; in_valid held high with new a/b during RUN -> ignored, in_ready=0 throughout RUN.
- Backpressure: out_ready=0 for 10 cycles after a=-500, b=2000 -> out_valid stays 1, result stays -1000000 (stable every cycle); accept on cycle 11 -> in_ready=1 next edge.
- Reset mid-op: pulse rst at step 15 of a=90, b=70 -> next edge in_ready=1, out_valid=0, result=0, and no result ever emitted for that pair; then a=-10, b=325 -> -3250.
- Back-to-back: in_valid and out_ready held high with 8 operand pairs -> 8 correct products, one every 34 cycles, no dropped or duplicated results.
